cmp_sample_packer: RTL and testbench

CMP_SAMPLE_PACKER -- requirements
Module: cmp_sample_packer

---
 rtl/cmp_sample_packer_if.sv | 26 ++
 rtl/cmp_sample_packer.sv | 130 +++++++++++++
 tb/tb_cmp_sample_packer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_sample_packer_if.sv
// Sample/stream bundle for cmp_sample_packer: comparator pad samples and
// capture enable in, packed 80-bit words out with a ready/valid handshake.
interface cmp_sample_packer_if;
  logic        cmp_data_p0;
  logic        cmp_data_p1;
  logic        cmp_data_p2;
  logic        cmp_data_p3;
  logic        cap_en;
  logic        gth_ready;
  logic [79:0] gth_data;
  logic        gth_valid;

  // Packer side: consumes samples, produces words.
  modport master (
    input  cmp_data_p0, cmp_data_p1, cmp_data_p2, cmp_data_p3,
    input  cap_en, gth_ready,
    output gth_data, gth_valid
  );

  // Environment side: supplies samples, consumes words.
  modport slave (
    output cmp_data_p0, cmp_data_p1, cmp_data_p2, cmp_data_p3,
    output cap_en, gth_ready,
    input  gth_data, gth_valid
  );
endinterface

// File: rtl/cmp_sample_packer.sv
// Packs four comparator pad bits per enabled cycle into 80-bit words
// (20 slots of 4 bits) and buffers completed words in a small FIFO toward
// the transceiver. Drops on overflow are flagged and counted.
module cmp_sample_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [79:0] IDLE_WORD  = '0
) (
  input  logic                          sample_clk,
  input  logic                          sample_rst_n,
  cmp_sample_packer_if.master           io,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_flag,
  output logic [15:0]                   ovf_cnt,
  output logic [31:0]                   word_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  // ST_PUSH means the next enabled sample lands in slot 19 and completes a word.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PUSH
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    k_q, k_d;
  logic [79:0]   asm_q, asm_d;
  logic [79:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;
  logic [31:0]   word_cnt_q, word_cnt_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic [3:0]    nib;

  // Packer: place the current nibble in slot k, advance k, flag completion.
  always_comb begin
    nib     = {io.cmp_data_p3, io.cmp_data_p2, io.cmp_data_p1, io.cmp_data_p0};
    asm_d   = asm_q;
    k_d     = k_q;
    state_d = state_q;
    push    = 1'b0;
    if (!io.cap_en) begin
      k_d     = '0;
      state_d = ST_IDLE;
    end else begin
      asm_d[{k_q, 2'b00} +: 4] = nib;
      if (state_q == ST_PUSH) begin
        push    = 1'b1;
        k_d     = '0;
        state_d = ST_FILL;
      end else begin
        k_d     = k_q + 5'd1;
        state_d = (k_q == 5'd18) ? ST_PUSH : ST_FILL;
      end
    end
  end

  // FIFO bookkeeping; a pop frees the head slot so a push into a full FIFO
  // still succeeds when both happen on the same edge.
  always_comb begin
    full       = (level_q == LW'(FIFO_DEPTH));
    pop        = (level_q != '0) && io.gth_ready;
    push_ok    = push && (!full || pop);
    drop       = push && full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LW'(1);
    end
    ovf_d      = ovf_q | drop;
    ovf_cnt_d  = (drop && (ovf_cnt_q != 16'hFFFF)) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
    word_cnt_d = pop ? word_cnt_q + 32'd1 : word_cnt_q;
  end

  // State, packer and FIFO control registers.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      ovf_cnt_q  <= ovf_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Word storage; content is never read while empty, so it needs no reset.
  always_ff @(posedge sample_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= asm_d;
    end
  end

  // Outputs come only from state and storage, never directly from inputs.
  always_comb begin
    io.gth_valid = (level_q != '0);
    io.gth_data  = io.gth_valid ? mem_q[rd_ptr_q] : IDLE_WORD;
    fifo_level   = level_q;
    ovf_flag     = ovf_q;
    ovf_cnt      = ovf_cnt_q;
    word_cnt     = word_cnt_q;
  end

endmodule

// File: tb/tb_cmp_sample_packer.sv
// Directed bench for cmp_sample_packer with FIFO_DEPTH=4 and a non-zero
// idle word, plus a randomized-ready stall run against a word queue.
module tb_cmp_sample_packer;

  localparam logic [79:0] IDLE  = 80'hA5A5_5A5A_C3C3_3C3C_0F0F;
  localparam logic [79:0] COUNT = 80'h3210FEDCBA9876543210;

  logic        sample_clk   = 1'b0;
  logic        sample_rst_n = 1'b1;
  logic [2:0]  fifo_level;
  logic        ovf_flag;
  logic [15:0] ovf_cnt;
  logic [31:0] word_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [79:0] q[$];
  int          pops     = 0;
  int          data_err = 0;
  int          stab_err = 0;
  logic        held_v   = 1'b0;
  logic [79:0] held_d;

  cmp_sample_packer_if bus ();

  cmp_sample_packer #(
    .FIFO_DEPTH (4),
    .IDLE_WORD  (IDLE)
  ) dut (
    .sample_clk   (sample_clk),
    .sample_rst_n (sample_rst_n),
    .io           (bus),
    .fifo_level   (fifo_level),
    .ovf_flag     (ovf_flag),
    .ovf_cnt      (ovf_cnt),
    .word_cnt     (word_cnt)
  );

  always #5 sample_clk = ~sample_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [79:0] rep(input logic [3:0] n);
    return {20{n}};
  endfunction

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic set_nib(input logic [3:0] n);
    bus.cmp_data_p0 = n[0];
    bus.cmp_data_p1 = n[1];
    bus.cmp_data_p2 = n[2];
    bus.cmp_data_p3 = n[3];
  endtask

  task automatic cap(input logic [3:0] n);
    bus.cap_en = 1'b1;
    set_nib(n);
    tick();
  endtask

  task automatic idle_tick();
    bus.cap_en = 1'b0;
    set_nib(4'h0);
    tick();
  endtask

  // Looks at the head before the edge on which rdy is presented.
  task automatic observe(input logic rdy);
    if (held_v && (bus.gth_data !== held_d)) stab_err++;
    held_v = 1'b0;
    if (bus.gth_valid) begin
      if (rdy) begin
        if (q.size() == 0 || q[0] !== bus.gth_data) data_err++;
        if (q.size() != 0) void'(q.pop_front());
        pops++;
      end else begin
        held_v = 1'b1;
        held_d = bus.gth_data;
      end
    end
  endtask

  initial begin
    logic [79:0] m;
    logic [3:0]  nib;
    logic        rdy;
    int          k;

    bus.cap_en    = 1'b0;
    bus.gth_ready = 1'b0;
    set_nib(4'h0);

    // Asynchronous reset values
    #1 sample_rst_n = 1'b0;
    #2;
    check("rst_valid", bus.gth_valid, 1'b0);
    check("rst_data", bus.gth_data, IDLE);
    check("rst_level", fifo_level, 3'd0);
    check("rst_ovf_flag", ovf_flag, 1'b0);
    check("rst_ovf_cnt", ovf_cnt, 16'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    tick();
    tick();
    sample_rst_n = 1'b1;

    // Ordering: 20 samples counting 0..19
    bus.gth_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cap(4'(i));
      if (i == 18) check("order_not_early", bus.gth_valid, 1'b0);
    end
    check("order_valid", bus.gth_valid, 1'b1);
    check("order_data", bus.gth_data, COUNT);
    check("order_level", fifo_level, 3'd1);
    idle_tick();
    check("order_valid_1cyc", bus.gth_valid, 1'b0);
    check("order_idle_data", bus.gth_data, IDLE);
    check("order_word_cnt", word_cnt, 32'd1);

    // Abort: 10 samples, one gap, then 20 all-ones samples
    for (int i = 0; i < 10; i++) cap(4'h0);
    idle_tick();
    for (int i = 0; i < 19; i++) cap(4'hF);
    check("abort_not_early", bus.gth_valid, 1'b0);
    cap(4'hF);
    check("abort_valid", bus.gth_valid, 1'b1);
    check("abort_data", bus.gth_data, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) idle_tick();
    check("abort_one_word", word_cnt, 32'd2);
    check("abort_valid_low", bus.gth_valid, 1'b0);

    // Overflow: six words into a depth-4 FIFO with no consumer
    bus.gth_ready = 1'b0;
    for (int w = 1; w <= 6; w++)
      for (int s = 0; s < 20; s++) cap(4'(w));
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_cnt", ovf_cnt, 16'd2);
    check("ovf_flag", ovf_flag, 1'b1);
    bus.gth_ready = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      check("ovf_drain_data", bus.gth_data, rep(4'(w)));
      idle_tick();
    end
    check("ovf_drain_valid", bus.gth_valid, 1'b0);
    check("ovf_drain_idle", bus.gth_data, IDLE);
    check("ovf_drain_wc", word_cnt, 32'd6);

    // Push and pop together on a full FIFO
    bus.gth_ready = 1'b0;
    for (int w = 7; w <= 11; w++)
      for (int s = 0; s < 20; s++) begin
        if (w == 11 && s == 19) bus.gth_ready = 1'b1;
        cap(4'(w));
        bus.gth_ready = 1'b0;
      end
    check("simul_level", fifo_level, 3'd4);
    check("simul_ovf_cnt", ovf_cnt, 16'd2);
    bus.gth_ready = 1'b1;
    for (int w = 8; w <= 11; w++) begin
      check("simul_drain_data", bus.gth_data, rep(4'(w)));
      idle_tick();
    end
    check("simul_empty", bus.gth_valid, 1'b0);
    check("simul_word_cnt", word_cnt, 32'd11);

    // Reset mid-word with three words queued
    bus.gth_ready = 1'b0;
    for (int w = 1; w <= 3; w++)
      for (int s = 0; s < 20; s++) cap(4'(w));
    for (int s = 0; s < 7; s++) cap(4'h4);
    check("midrst_level_pre", fifo_level, 3'd3);
    #2 sample_rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.gth_valid, 1'b0);
    check("midrst_data", bus.gth_data, IDLE);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_ovf_flag", ovf_flag, 1'b0);
    check("midrst_ovf_cnt", ovf_cnt, 16'd0);
    check("midrst_word_cnt", word_cnt, 32'd0);
    cap(4'h5);
    cap(4'h5);
    sample_rst_n = 1'b1;
    for (int i = 0; i < 19; i++) cap(4'(i));
    check("postrst_not_early", bus.gth_valid, 1'b0);
    cap(4'h3);
    check("postrst_valid", bus.gth_valid, 1'b1);
    check("postrst_data", bus.gth_data, COUNT);
    bus.gth_ready = 1'b1;
    idle_tick();
    check("postrst_word_cnt", word_cnt, 32'd1);

    // Stall: 1000 random words with a randomly toggling consumer
    m = '0;
    k = 0;
    for (int c = 0; c < 20000; c++) begin
      rdy = 1'($urandom_range(0, 1));
      observe(rdy);
      nib = 4'($urandom);
      m[4*k +: 4] = nib;
      if (k == 19) begin
        q.push_back(m);
        k = 0;
      end else begin
        k++;
      end
      bus.gth_ready = rdy;
      cap(nib);
    end
    for (int c = 0; c < 12; c++) begin
      observe(1'b1);
      bus.gth_ready = 1'b1;
      idle_tick();
    end
    check("stall_data_errs", 80'(data_err), 80'd0);
    check("stall_hold_errs", 80'(stab_err), 80'd0);
    check("stall_pops", 80'(pops), 80'd1000);
    check("stall_queue_left", 80'(q.size()), 80'd0);
    check("stall_word_cnt", word_cnt, 32'(1 + pops));
    check("stall_no_ovf", ovf_flag, 1'b0);
    check("stall_level", fifo_level, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
